// File: rtl/inst_sram_responder.sv
// inst_sram_responder: in-order SRAM-like target answering req/addr_ok/data_ok requests from an internal word array after LATENCY cycles
//   in:  clk, reset (async, active-high), req, wr, size, wstrb, addr, wdata, addr_stall
//   out: addr_ok (comb accept), data_ok (one pulse per accepted request), rdata (read word, 0 for writes)
module inst_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_stall
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [3:0] TINIT = 4'(LATENCY - 1);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic wr_q [DEPTH];
  logic wr_d [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_d [DEPTH];
  logic [3:0] tmr_q [DEPTH];
  logic [3:0] tmr_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] cnt_q, cnt_d;
  logic data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic acc, ret;
  logic [ADDR_WIDTH-1:0] widx;
  logic unused;
  assign unused = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};
  assign widx = addr[ADDR_WIDTH+1:2];
  // Full check uses the registered count only: a same-cycle retire does not free a slot.
  assign addr_ok = ~reset & ~addr_stall & (cnt_q != FULL);
  assign acc = req & addr_ok;
  assign ret = (cnt_q != '0) & (tmr_q[head_q] == '0);
  assign data_ok = data_ok_q;
  assign rdata = rdata_q;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_d[i] = wr_q[i];
      idx_d[i] = idx_q[i];
      // Every slot counts down independently so queued entries age while waiting behind the head.
      tmr_d[i] = (tmr_q[i] != '0) ? tmr_q[i] - 4'd1 : '0;
    end
    if (acc) begin
      wr_d[tail_q] = wr;
      idx_d[tail_q] = widx;
      tmr_d[tail_q] = TINIT;
    end
    head_d = ret ? head_q + PW'(1) : head_q;
    tail_d = acc ? tail_q + PW'(1) : tail_q;
    cnt_d = cnt_q + (PW+1)'(acc) - (PW+1)'(ret);
    data_ok_d = ret;
    rdata_d = ret ? (wr_q[head_q] ? '0 : mem[idx_q[head_q]]) : rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      data_ok_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wr_q[i] <= 1'b0;
        idx_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        wr_q[i] <= wr_d[i];
        idx_q[i] <= idx_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end
  // Writes commit at acceptance, so later reads of the same word see the new data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (acc && wr && wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  end
  always @(posedge clk)
    if (!reset) assert (!$isunknown(req)) else $error("req is X/Z outside reset");
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: directed scoreboard bench for inst_sram_responder at LATENCY 2, 8 and 1
module tb_inst_sram_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  localparam int LAT [3] = '{2, 8, 1};
  logic req [3], wr [3], stall [3], aok [3], dok [3];
  logic [1:0] size [3];
  logic [3:0] strb [3];
  logic [31:0] addr [3], wdata [3], rdata [3];
  inst_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]), .wstrb(strb[0]),
    .addr(addr[0]), .wdata(wdata[0]), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdata[0]),
    .addr_stall(stall[0]));
  inst_sram_responder #(.ADDR_WIDTH(10), .LATENCY(8), .DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]), .wstrb(strb[1]),
    .addr(addr[1]), .wdata(wdata[1]), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdata[1]),
    .addr_stall(stall[1]));
  inst_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size[2]), .wstrb(strb[2]),
    .addr(addr[2]), .wdata(wdata[2]), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rdata[2]),
    .addr_stall(stall[2]));
  typedef struct {
    logic [31:0] data;
    int due;
  } exp_t;
  exp_t sb [3][$];
  logic [31:0] mdl [3][1024];
  int last_ret [3];
  int cyc = 0;
  int checks = 0, passed = 0, fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Call between a rising edge and the next falling edge; returns the edge index of acceptance.
  task automatic issue(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int acc_edge, output int waits);
    exp_t e;
    int idx;
    idx = int'(a[11:2]);
    waits = 0;
    req[k] = 1'b1;
    wr[k] = w;
    strb[k] = s;
    addr[k] = a;
    wdata[k] = d;
    @(negedge clk);
    while (!aok[k] && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits == 50) chk("accept_timeout", 32'(aok[k]), 32'd1);
    acc_edge = cyc + 1;
    if (w) for (int i = 0; i < 4; i++) if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
    e.data = w ? 32'h0 : mdl[k][idx];
    e.due = (acc_edge + LAT[k] > last_ret[k] + 1) ? acc_edge + LAT[k] : last_ret[k] + 1;
    last_ret[k] = e.due;
    sb[k].push_back(e);
    tick();
    req[k] = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb[0].size() + sb[1].size() + sb[2].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
    tick();
  endtask
  always @(negedge clk)
    if (!reset)
      for (int k = 0; k < 3; k++)
        if (dok[k]) begin
          if (sb[k].size() == 0) chk("spurious_data_ok", 32'(dok[k]), 32'd0);
          else begin
            exp_t e;
            e = sb[k].pop_front();
            chk("rdata", rdata[k], e.data);
            chk("data_ok_cycle", 32'(cyc), 32'(e.due));
          end
        end
  initial begin
    int a, w, a1, prev;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      wr[k] = 1'b0;
      stall[k] = 1'b0;
      size[k] = 2'd2;
      strb[k] = 4'h0;
      addr[k] = '0;
      wdata[k] = '0;
      last_ret[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_addr_ok", 32'(aok[k]), 32'd0);
      chk("rst_data_ok", 32'(dok[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
    end
    reset = 1'b0;
    tick();
    // write then read, both accepted immediately
    issue(0, 1'b1, 4'hF, 32'h10, 32'h1234_5678, a, w);
    chk("t1_wr_wait", 32'(w), 32'd0);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, a, w);
    chk("t1_rd_wait", 32'(w), 32'd0);
    drain();
    // byte-lane merge, low address bits ignored
    issue(0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD, a, w);
    issue(0, 1'b1, 4'b0010, 32'h20, 32'h0000_1100, a, w);
    issue(0, 1'b0, 4'h0, 32'h23, 32'h0, a, w);
    drain();
    chk("lane_merge_model", mdl[0][8], 32'hAABB_11DD);
    // full queue, LATENCY 8
    for (int i = 0; i < 5; i++) issue(1, 1'b1, 4'hF, 32'h40 + 32'(4*i), 32'hC0DE_0000 + 32'(i), a, w);
    drain();
    issue(1, 1'b0, 4'h0, 32'h40, 32'h0, a1, w);
    for (int i = 1; i < 4; i++) issue(1, 1'b0, 4'h0, 32'h40 + 32'(4*i), 32'h0, a, w);
    @(negedge clk);
    chk("full_addr_ok", 32'(aok[1]), 32'd0);
    tick();
    issue(1, 1'b0, 4'h0, 32'h50, 32'h0, a, w);
    chk("full_fifth_accept_edge", 32'(a), 32'(a1 + 9));
    drain();
    // back-to-back streaming, LATENCY 1
    for (int i = 0; i < 8; i++) issue(2, 1'b1, 4'hF, 32'(4*i), 32'(i), a, w);
    drain();
    issue(2, 1'b0, 4'h0, 32'h0, 32'h0, prev, w);
    for (int i = 1; i < 8; i++) begin
      issue(2, 1'b0, 4'h0, 32'(4*i), 32'h0, a, w);
      chk("stream_accept_edge", 32'(a), 32'(prev + 1));
      prev = a;
    end
    drain();
    // address wrap
    issue(0, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF, a, w);
    issue(0, 1'b0, 4'h0, 32'h0, 32'h0, a, w);
    drain();
    // back-pressure, then reset with requests in flight
    req[0] = 1'b1;
    wr[0] = 1'b0;
    addr[0] = 32'h10;
    stall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr_ok", 32'(aok[0]), 32'd0);
      chk("stall_data_ok", 32'(dok[0]), 32'd0);
    end
    tick();
    stall[0] = 1'b0;
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, a, w);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, a, w);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_data_ok", 32'(dok[0]), 32'd0);
    chk("async_rst_addr_ok", 32'(aok[0]), 32'd0);
    chk("async_rst_rdata", rdata[0], 32'd0);
    for (int k = 0; k < 3; k++) begin
      sb[k].delete();
      last_ret[k] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_data_ok", 32'(dok[0]), 32'd0);
    end
    chk("post_rst_addr_ok", 32'(aok[0]), 32'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
